// File: rtl/mem_ctrl.sv
// Byte-serial arbiter/sequencer sharing one byte-wide RAM port between instruction fetch and MEM.
// Requests are split into little-endian byte beats; read bytes are reassembled, zero-extended.
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    input  logic                  if_cancel_i,
    output logic [31:0]           if_data_o,
    output logic                  if_done_o,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [1:0]            mem_size_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [31:0]           mem_wdata_i,
    output logic [31:0]           mem_rdata_o,
    output logic                  mem_done_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [7:0]            ram_dout_o,
    output logic                  ram_wr_o,
    input  logic [7:0]            ram_din_i,
    output logic                  busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        IF_RD,
        MEM_RD,
        MEM_WR,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [2:0]            nbytes;
    logic [2:0]            cnt;      // cycle number within the transaction, starts at 1
    logic [2:0]            cap_idx;
    logic [ADDR_WIDTH-1:0] next_addr;

    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Byte addressed in cycle c arrives in cycle c+1, so cycle c captures byte c-2.
    assign cap_idx   = cnt - 3'd2;
    assign next_addr = addr_q + ADDR_WIDTH'(cnt);
    assign busy_o    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            nbytes      <= '0;
            cnt         <= '0;
            if_data_o   <= '0;
            if_done_o   <= 1'b0;
            mem_rdata_o <= '0;
            mem_done_o  <= 1'b0;
            ram_addr_o  <= '0;
            ram_dout_o  <= '0;
            ram_wr_o    <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every branch below reads pre-edge register values.
            if_done_o  <= 1'b0;
            mem_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req_i) begin
                        addr_q      <= mem_addr_i;
                        wdata_q     <= mem_wdata_i;
                        nbytes      <= size_to_n(mem_size_i);
                        cnt         <= 3'd1;
                        ram_addr_o  <= mem_addr_i;
                        mem_rdata_o <= '0;
                        if (mem_we_i) begin
                            state      <= MEM_WR;
                            ram_wr_o   <= 1'b1;
                            ram_dout_o <= mem_wdata_i[7:0];
                        end else begin
                            state <= MEM_RD;
                        end
                    end else if (if_req_i && !if_cancel_i) begin
                        addr_q     <= if_addr_i;
                        nbytes     <= 3'd4;
                        cnt        <= 3'd1;
                        ram_addr_o <= if_addr_i;
                        if_data_o  <= '0;
                        state      <= IF_RD;
                    end
                end

                IF_RD, MEM_RD: begin
                    if (state == IF_RD && if_cancel_i) begin
                        state      <= IDLE;
                        ram_addr_o <= '0;
                    end else begin
                        ram_addr_o <= (cnt < nbytes) ? next_addr : '0;
                        if (cnt >= 3'd2) begin
                            if (state == IF_RD)
                                if_data_o[{cap_idx[1:0], 3'b000} +: 8] <= ram_din_i;
                            else
                                mem_rdata_o[{cap_idx[1:0], 3'b000} +: 8] <= ram_din_i;
                        end
                        if (cnt == nbytes + 3'd1) begin
                            state <= DONE;
                            if (state == IF_RD)
                                if_done_o <= 1'b1;
                            else
                                mem_done_o <= 1'b1;
                        end
                        cnt <= cnt + 3'd1;
                    end
                end

                MEM_WR: begin
                    if (cnt < nbytes) begin
                        ram_addr_o <= next_addr;
                        ram_dout_o <= wdata_q[{cnt[1:0], 3'b000} +: 8];
                    end else begin
                        ram_wr_o   <= 1'b0;
                        ram_addr_o <= '0;
                        ram_dout_o <= '0;
                        mem_done_o <= 1'b1;
                        state      <= DONE;
                    end
                    cnt <= cnt + 3'd1;
                end

                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: per-cycle expectations are queued as stimulus is planned and
// popped against the DUT one cycle at a time; a 4 KiB byte RAM model answers the RAM port.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i, if_cancel_i, mem_req_i, mem_we_i;
    logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i;
    logic [1:0]  mem_size_i;
    logic [31:0] if_data_o, mem_rdata_o, ram_addr_o;
    logic        if_done_o, mem_done_o, ram_wr_o, busy_o;
    logic [7:0]  ram_dout_o, ram_din;

    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;
    string test_name;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [7:0]  dout;
        logic        if_done;
        logic        mem_done;
        logic        busy;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    logic [7:0] ram [0:4095];

    mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_cancel_i(if_cancel_i),
        .if_data_o  (if_data_o),
        .if_done_o  (if_done_o),
        .mem_req_i  (mem_req_i),
        .mem_we_i   (mem_we_i),
        .mem_size_i (mem_size_i),
        .mem_addr_i (mem_addr_i),
        .mem_wdata_i(mem_wdata_i),
        .mem_rdata_o(mem_rdata_o),
        .mem_done_o (mem_done_o),
        .ram_addr_o (ram_addr_o),
        .ram_dout_o (ram_dout_o),
        .ram_wr_o   (ram_wr_o),
        .ram_din_i  (ram_din),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data appears the cycle after its address.
    always @(posedge clk) begin
        if (ram_wr_o) ram[ram_addr_o[11:0]] <= ram_dout_o;
        ram_din <= ram[ram_addr_o[11:0]];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic wr, input logic [7:0] d,
                        input logic ifd, input logic md, input logic b, input logic [31:0] data);
        exp_t e;
        e.addr = a; e.wr = wr; e.dout = d; e.if_done = ifd; e.mem_done = md; e.busy = b; e.data = data;
        sb.push_back(e);
    endtask

    task automatic push_idle();
        push(32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic push_read(input logic is_if, input logic [31:0] a, input int n, input logic [31:0] data);
        for (int i = 1; i <= n; i++) push(a + 32'(i - 1), 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0);
        push(32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0);
        push(32'h0, 1'b0, 8'h00, is_if, !is_if, 1'b1, data);
    endtask

    task automatic push_write(input logic [31:0] a, input int n, input logic [31:0] wd);
        logic [31:0] sh;
        for (int i = 1; i <= n; i++) begin
            sh = wd >> (8 * (i - 1));
            push(a + 32'(i - 1), 1'b1, sh[7:0], 1'b0, 1'b0, 1'b1, 32'h0);
        end
        push(32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h0);
    endtask

    task automatic check_cycle();
        exp_t  e;
        string t;
        e = sb.pop_front();
        t = $sformatf("%s c%0d", test_name, cyc);
        check({t, " ram_addr"}, ram_addr_o, e.addr);
        check({t, " ram_wr"}, {31'b0, ram_wr_o}, {31'b0, e.wr});
        check({t, " ram_dout"}, {24'b0, ram_dout_o}, {24'b0, e.dout});
        check({t, " if_done"}, {31'b0, if_done_o}, {31'b0, e.if_done});
        check({t, " mem_done"}, {31'b0, mem_done_o}, {31'b0, e.mem_done});
        check({t, " busy"}, {31'b0, busy_o}, {31'b0, e.busy});
        if (e.if_done)  check({t, " if_data"}, if_data_o, e.data);
        if (e.mem_done) check({t, " mem_rdata"}, mem_rdata_o, e.data);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic mem_request(input logic we, input logic [1:0] size, input logic [31:0] a, input logic [31:0] wd);
        mem_req_i = 1'b1; mem_we_i = we; mem_size_i = size; mem_addr_i = a; mem_wdata_i = wd;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h00; ram[12'h102] = 8'h00; ram[12'h103] = 8'h93;
        ram[12'h031] = 8'h80; ram[12'h032] = 8'hFF;
        ram[12'h007] = 8'hAB;
        ram[12'hFFE] = 8'h11; ram[12'hFFF] = 8'h22; ram[12'h000] = 8'h33; ram[12'h001] = 8'h44;

        rst = 1'b1;
        if_req_i = 1'b0; if_cancel_i = 1'b0; if_addr_i = '0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_size_i = '0; mem_addr_i = '0; mem_wdata_i = '0;
        #1;
        test_name = "reset";
        check("reset ram_addr", ram_addr_o, 32'h0);
        check("reset ram_wr", {31'b0, ram_wr_o}, 32'h0);
        check("reset busy", {31'b0, busy_o}, 32'h0);
        check("reset if_data", if_data_o, 32'h0);
        check("reset mem_rdata", mem_rdata_o, 32'h0);
        check("reset done", {30'b0, if_done_o, mem_done_o}, 32'h0);
        step(); step();
        rst = 1'b0;
        step();

        // IF word fetch at 0x100.
        test_name = "if_fetch";
        push_idle(); push_read(1'b1, 32'h100, 4, 32'h93000013); push_idle();
        if_req_i = 1'b1; if_addr_i = 32'h100; cyc = 0;
        while (sb.size() > 0) begin
            if (cyc == 1) if_req_i = 1'b0;
            check_cycle(); step();
        end

        // Simultaneous store and IF: store wins, IF then reads back the stored word.
        test_name = "prio";
        push_idle(); push_write(32'h20, 4, 32'hDEADBEEF);
        push_idle(); push_read(1'b1, 32'h20, 4, 32'hDEADBEEF); push_idle();
        mem_request(1'b1, 2'b10, 32'h20, 32'hDEADBEEF);
        if_req_i = 1'b1; if_addr_i = 32'h20; cyc = 0;
        while (sb.size() > 0) begin
            if (cyc == 1) mem_req_i = 1'b0;
            if (cyc == 7) if_req_i = 1'b0;
            check_cycle(); step();
        end

        // Loads: LH misaligned, LB (upper bytes cleared), LW with size 11.
        test_name = "lh";
        push_idle(); push_read(1'b0, 32'h31, 2, 32'h0000FF80); push_idle();
        mem_request(1'b0, 2'b01, 32'h31, 32'hFFFFFFFF); cyc = 0;
        while (sb.size() > 0) begin
            if (cyc == 1) mem_req_i = 1'b0;
            check_cycle(); step();
        end
        test_name = "lb";
        push_idle(); push_read(1'b0, 32'h7, 1, 32'h000000AB); push_idle();
        mem_request(1'b0, 2'b00, 32'h7, 32'h0); cyc = 0;
        while (sb.size() > 0) begin
            if (cyc == 1) mem_req_i = 1'b0;
            check_cycle(); step();
        end
        test_name = "lw11";
        push_idle(); push_read(1'b0, 32'h100, 4, 32'h93000013); push_idle();
        mem_request(1'b0, 2'b11, 32'h100, 32'h0); cyc = 0;
        while (sb.size() > 0) begin
            if (cyc == 1) mem_req_i = 1'b0;
            check_cycle(); step();
        end

        // IF fetch wrapping past the top of the address space.
        test_name = "wrap";
        push_idle(); push_read(1'b1, 32'hFFFFFFFE, 4, 32'h44332211); push_idle();
        if_req_i = 1'b1; if_addr_i = 32'hFFFFFFFE; cyc = 0;
        while (sb.size() > 0) begin
            if (cyc == 1) if_req_i = 1'b0;
            check_cycle(); step();
        end

        // Cancel alongside a request in IDLE blocks acceptance.
        test_name = "cancel_idle";
        push_idle(); push_idle(); push_idle();
        if_req_i = 1'b1; if_cancel_i = 1'b1; if_addr_i = 32'h100; cyc = 0;
        while (sb.size() > 0) begin
            if (cyc == 1) begin if_req_i = 1'b0; if_cancel_i = 1'b0; end
            check_cycle(); step();
        end

        // Cancel in cycle 2 of an IF read; a queued LB is accepted in cycle 3.
        test_name = "cancel";
        push_idle();
        push(32'h100, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0);
        push(32'h101, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0);
        push_idle(); push_read(1'b0, 32'h7, 1, 32'h000000AB); push_idle();
        if_req_i = 1'b1; if_addr_i = 32'h100; cyc = 0;
        while (sb.size() > 0) begin
            if (cyc == 1) begin if_req_i = 1'b0; mem_request(1'b0, 2'b00, 32'h7, 32'h0); end
            if (cyc == 2) if_cancel_i = 1'b1;
            if (cyc == 3) if_cancel_i = 1'b0;
            if (cyc == 4) mem_req_i = 1'b0;
            check_cycle(); step();
        end

        // Asynchronous reset in cycle 2 of a word store.
        test_name = "rst_sw";
        push_idle();
        push(32'h40, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 32'h0);
        push(32'h41, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 32'h0);
        mem_request(1'b1, 2'b10, 32'h40, 32'h11223344); cyc = 0;
        for (int k = 0; k < 3; k++) begin
            if (cyc == 1) mem_req_i = 1'b0;
            check_cycle();
            if (k < 2) step();
        end
        #3 rst = 1'b1;
        #1;
        check("rst_sw async ram_wr", {31'b0, ram_wr_o}, 32'h0);
        check("rst_sw async ram_addr", ram_addr_o, 32'h0);
        check("rst_sw async busy", {31'b0, busy_o}, 32'h0);
        step();
        check("rst_sw held mem_done", {31'b0, mem_done_o}, 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("rst_sw after%0d busy", k), {31'b0, busy_o}, 32'h0);
            check($sformatf("rst_sw after%0d mem_done", k), {31'b0, mem_done_o}, 32'h0);
            check($sformatf("rst_sw after%0d ram_wr", k), {31'b0, ram_wr_o}, 32'h0);
        end
        check("rst_sw ram[0x40]", {24'b0, ram[12'h040]}, 32'h44);
        check("rst_sw ram[0x41]", {24'b0, ram[12'h041]}, 32'h00);
        check("rst_sw ram[0x43]", {24'b0, ram[12'h043]}, 32'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Arbiter and sequencer for the single byte-wide RAM port. It is shared by instruction fetch (IF, word reads) and the MEM stage (loads and stores at the address computed by the execute stage). Each request is split into little-endian byte beats and driven onto the RAM. Read bytes are reassembled and the transaction is completed with a done pulse. Sign extension of loads stays in MEM; this block returns raw bytes, zero-extended.

Parameters:
ADDR_WIDTH, 32, width of all address ports; byte addresses wrap modulo 2^ADDR_WIDTH.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
if_req_i  input  1  IF requests a 32-bit instruction read
if_addr_i  input  ADDR_WIDTH  IF byte address
if_cancel_i  input  1  abort an in-flight IF read (branch flush)
if_data_o  output  32  fetched instruction, valid while if_done_o=1
if_done_o  output  1  one-cycle IF completion pulse
mem_req_i  input  1  MEM requests a load or store
mem_we_i  input  1  1 = store, 0 = load
mem_size_i  input  2  00 byte, 01 half, 10 or 11 word
mem_addr_i  input  ADDR_WIDTH  MEM byte address
mem_wdata_i  input  32  store data; low bytes used
mem_rdata_o  output  32  load data, zero-extended, valid while mem_done_o=1
mem_done_o  output  1  one-cycle MEM completion pulse
ram_addr_o  output  ADDR_WIDTH  RAM byte address
ram_dout_o  output  8  RAM write byte
ram_wr_o  output  1  RAM write strobe
ram_din_i  input  8  RAM read byte; valid one cycle after its address
busy_o  output  1  transaction in progress (state != IDLE)

Behaviour:
- Reset: every output is 0 and the state is IDLE. Reset during a transaction aborts it with no done pulse and no further RAM writes.
- States and transitions:
  - IDLE: accepts a request.
  - IF_RD: IF read in progress.
  - MEM_RD: load in progress.
  - MEM_WR: store in progress.
  - DONE: drives the done pulse, then always returns to IDLE.
- Acceptance happens only in IDLE, at the clock edge where a request is high. Cycle 0 is the cycle in which the request is sampled.
- Priority: mem_req_i wins over if_req_i when both are high. There is no preemption once a transaction is accepted.
- Address, size, write data and the requester are latched at accept. Input changes after accept are ignored.
- Byte count N: 1, 2 or 4 according to size; IF reads always use N=4.
- Read timing:
  - Cycles 1..N: ram_addr_o = A+i-1, ram_wr_o=0.
  - Byte k (returned by address A+k) is captured at the end of cycle k+2, into bits [8k+7:8k].
  - Cycle N+2 is DONE with the done pulse.
  - Latency from request cycle to done is N+2 cycles.
- Write timing:
  - Cycles 1..N: ram_wr_o=1, ram_addr_o = A+i-1, ram_dout_o = wdata byte i-1.
  - Cycle N+1 is DONE with mem_done_o.
- Outside address and write beats: ram_addr_o=0, ram_dout_o=0, ram_wr_o=0.
- Done pulse: exactly one of if_done_o or mem_done_o is high, for one cycle, in DONE. Data outputs hold their value until the next accept.
- Requester obligation: deassert the request in the cycle after the done pulse. The arbiter resamples requests starting in the cycle after DONE.
- Address wrap: A+i is computed modulo 2^ADDR_WIDTH, and misaligned addresses are legal.
- Cancel:
  - if_cancel_i high in any cycle of IF_RD aborts the read. The next state is IDLE, no if_done_o is issued, and no further address beats are driven.
  - if_cancel_i high in IDLE together with if_req_i blocks acceptance of IF in that cycle.
  - if_cancel_i has no effect on MEM transactions.
- Unused upper bytes of mem_rdata_o are 0 for byte and half loads.

Test Plan:
- Reset, then IF read at 0x100 with ram bytes 13,00,00,93. Required: addresses 0x100..0x103 in cycles 1..4, if_done_o in cycle 6, if_data_o=0x93000013.
- Same-cycle mem_req (SW of 0xDEADBEEF to 0x20) and if_req. Required: store first, with ram_wr_o=1 and bytes EF,BE,AD,DE at 0x20..0x23 in cycles 1..4, mem_done_o in cycle 5. IF is then accepted in cycle 6 and its done arrives 6 cycles later.
- LH at 0x31 with bytes 0x80,0xFF. Required: mem_rdata_o=0x0000FF80 in cycle 4. LB at 0x7 with byte 0xAB: mem_rdata_o=0x000000AB in cycle 3.
- IF read at 0xFFFFFFFE. Required: addresses FFFFFFFE, FFFFFFFF, 0, 1 (wrap).
- IF read with if_cancel_i pulsed in cycle 2. Required: no address beat in cycle 3, no if_done_o, busy_o=0 in cycle 3. A queued mem_req is accepted in cycle 3.
- Assert rst asynchronously during cycle 2 of an SW. Required: ram_wr_o drops to 0 immediately, no mem_done_o, state IDLE after rst releases.
